// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: shares one i2c_master command/data interface between two
// requesters. A grant is held for a whole I2C transaction (through the command
// carrying cmd_stop). A stalled owner is evicted after TIMEOUT quiet cycles and
// the arbiter closes the bus with a standalone stop of its own.
//
// Handshake rule on every channel: a transfer happens in a cycle where valid and
// ready are both high; valid never waits on ready, and the arbiter only ever
// forwards the owner's valid/ready, so the rule is preserved end to end.
//
// The FSM state is fully visible on the ports: IDLE = busy 0; OWN0 = grant 01;
// OWN1 = grant 10; FSTOP = busy 1 with grant 00.
module i2c_master_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] s0_cmd_address,
    input  logic       s0_cmd_start,
    input  logic       s0_cmd_read,
    input  logic       s0_cmd_write,
    input  logic       s0_cmd_write_multiple,
    input  logic       s0_cmd_stop,
    input  logic       s0_cmd_valid,
    output logic       s0_cmd_ready,
    input  logic [7:0] s0_data_out,
    input  logic       s0_data_out_valid,
    input  logic       s0_data_out_last,
    output logic       s0_data_out_ready,
    output logic [7:0] s0_data_in,
    output logic       s0_data_in_valid,
    output logic       s0_data_in_last,
    input  logic       s0_data_in_ready,
    input  logic [6:0] s1_cmd_address,
    input  logic       s1_cmd_start,
    input  logic       s1_cmd_read,
    input  logic       s1_cmd_write,
    input  logic       s1_cmd_write_multiple,
    input  logic       s1_cmd_stop,
    input  logic       s1_cmd_valid,
    output logic       s1_cmd_ready,
    input  logic [7:0] s1_data_out,
    input  logic       s1_data_out_valid,
    input  logic       s1_data_out_last,
    output logic       s1_data_out_ready,
    output logic [7:0] s1_data_in,
    output logic       s1_data_in_valid,
    output logic       s1_data_in_last,
    input  logic       s1_data_in_ready,
    output logic [6:0] m_cmd_address,
    output logic       m_cmd_start,
    output logic       m_cmd_read,
    output logic       m_cmd_write,
    output logic       m_cmd_write_multiple,
    output logic       m_cmd_stop,
    output logic       m_cmd_valid,
    input  logic       m_cmd_ready,
    output logic [7:0] m_data_out,
    output logic       m_data_out_valid,
    output logic       m_data_out_last,
    input  logic       m_data_out_ready,
    input  logic [7:0] m_data_in,
    input  logic       m_data_in_valid,
    input  logic       m_data_in_last,
    output logic       m_data_in_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_evt
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, FSTOP} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state, state_next;
    logic        last_grant, last_grant_next;   // port that owned the bus last
    logic        fstop_port, fstop_port_next;   // port evicted by the timeout
    logic [15:0] quiet_cnt, quiet_cnt_next;
    logic        evt_next;

    logic own0, own1, in_fstop;
    logic owner_hs, owner_quiet, stop_accept;

    // Reset gates the mux so the master sees valid drop in the reset cycle itself.
    assign own0     = (state == OWN0) && !rst;
    assign own1     = (state == OWN1) && !rst;
    assign in_fstop = (state == FSTOP) && !rst;

    assign grant = {own1, own0};
    assign busy  = (state != IDLE) && !rst;

    // Read data is broadcast; only the owner ever sees valid.
    assign s0_data_in = m_data_in;
    assign s1_data_in = m_data_in;

    // Owner-side events, meaningful only while OWN0/OWN1 (mux outputs are the owner's).
    assign owner_hs    = (m_cmd_valid && m_cmd_ready) ||
                         (m_data_out_valid && m_data_out_ready) ||
                         (m_data_in_valid && m_data_in_ready);
    assign owner_quiet = !m_cmd_valid && !m_data_out_valid;
    assign stop_accept = m_cmd_valid && m_cmd_ready && m_cmd_stop;

    // Combinational mux from the registered grant to the master and back.
    always_comb begin
        m_cmd_address        = '0;
        m_cmd_start          = 1'b0;
        m_cmd_read           = 1'b0;
        m_cmd_write          = 1'b0;
        m_cmd_write_multiple = 1'b0;
        m_cmd_stop           = 1'b0;
        m_cmd_valid          = 1'b0;
        m_data_out           = '0;
        m_data_out_valid     = 1'b0;
        m_data_out_last      = 1'b0;
        m_data_in_ready      = 1'b1;   // no owner: read data is drained and dropped
        s0_cmd_ready         = 1'b0;
        s0_data_out_ready    = 1'b0;
        s0_data_in_valid     = 1'b0;
        s0_data_in_last      = 1'b0;
        s1_cmd_ready         = 1'b0;
        s1_data_out_ready    = 1'b0;
        s1_data_in_valid     = 1'b0;
        s1_data_in_last      = 1'b0;
        if (own0) begin
            m_cmd_address        = s0_cmd_address;
            m_cmd_start          = s0_cmd_start;
            m_cmd_read           = s0_cmd_read;
            m_cmd_write          = s0_cmd_write;
            m_cmd_write_multiple = s0_cmd_write_multiple;
            m_cmd_stop           = s0_cmd_stop;
            m_cmd_valid          = s0_cmd_valid;
            m_data_out           = s0_data_out;
            m_data_out_valid     = s0_data_out_valid;
            m_data_out_last      = s0_data_out_last;
            m_data_in_ready      = s0_data_in_ready;
            s0_cmd_ready         = m_cmd_ready;
            s0_data_out_ready    = m_data_out_ready;
            s0_data_in_valid     = m_data_in_valid;
            s0_data_in_last      = m_data_in_last;
        end else if (own1) begin
            m_cmd_address        = s1_cmd_address;
            m_cmd_start          = s1_cmd_start;
            m_cmd_read           = s1_cmd_read;
            m_cmd_write          = s1_cmd_write;
            m_cmd_write_multiple = s1_cmd_write_multiple;
            m_cmd_stop           = s1_cmd_stop;
            m_cmd_valid          = s1_cmd_valid;
            m_data_out           = s1_data_out;
            m_data_out_valid     = s1_data_out_valid;
            m_data_out_last      = s1_data_out_last;
            m_data_in_ready      = s1_data_in_ready;
            s1_cmd_ready         = m_cmd_ready;
            s1_data_out_ready    = m_data_out_ready;
            s1_data_in_valid     = m_data_in_valid;
            s1_data_in_last      = m_data_in_last;
        end else if (in_fstop) begin
            m_cmd_stop  = 1'b1;
            m_cmd_valid = 1'b1;
        end
    end

    // Next-state logic: arbitration, release on stop, timeout eviction.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        fstop_port_next = fstop_port;
        quiet_cnt_next  = quiet_cnt;
        evt_next        = 1'b0;
        case (state)
            IDLE: begin
                quiet_cnt_next = '0;
                if (s0_cmd_valid && s1_cmd_valid) begin
                    if ((ROUND_ROBIN != 0) && !last_grant) state_next = OWN1;
                    else                                    state_next = OWN0;
                end else if (s0_cmd_valid) begin
                    state_next = OWN0;
                end else if (s1_cmd_valid) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (owner_hs)         quiet_cnt_next = '0;
                else if (owner_quiet) quiet_cnt_next = quiet_cnt + 16'd1;
                if (stop_accept) begin
                    // A stop accept always wins over a coinciding timeout.
                    state_next      = IDLE;
                    last_grant_next = (state == OWN1);
                end else if ((TIMEOUT != 0) && (quiet_cnt_next == TIMEOUT_CNT)) begin
                    state_next      = FSTOP;
                    fstop_port_next = (state == OWN1);
                    evt_next        = 1'b1;
                end
            end
            FSTOP: begin
                if (m_cmd_ready) begin
                    state_next      = IDLE;
                    last_grant_next = fstop_port;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and bookkeeping registers; timeout_evt is high for the first FSTOP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            fstop_port  <= 1'b0;
            quiet_cnt   <= '0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_next;
            last_grant  <= last_grant_next;
            fstop_port  <= fstop_port_next;
            quiet_cnt   <= quiet_cnt_next;
            timeout_evt <= evt_next;
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter. Instance dut uses round-robin with TIMEOUT=8;
// instance dut_fp uses fixed priority with the timeout disabled. Both see the
// same requester and master-side stimulus; expected grants come from the
// arbitration rules applied to a per-instance record of the last owner.
module tb_i2c_master_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] s0_cmd_address, s1_cmd_address;
    logic       s0_cmd_start, s0_cmd_read, s0_cmd_write, s0_cmd_write_multiple, s0_cmd_stop, s0_cmd_valid;
    logic       s1_cmd_start, s1_cmd_read, s1_cmd_write, s1_cmd_write_multiple, s1_cmd_stop, s1_cmd_valid;
    logic [7:0] s0_data_out, s1_data_out;
    logic       s0_data_out_valid, s0_data_out_last, s1_data_out_valid, s1_data_out_last;
    logic       s0_data_in_ready, s1_data_in_ready;
    logic       m_cmd_ready, m_data_out_ready;
    logic [7:0] m_data_in;
    logic       m_data_in_valid, m_data_in_last;

    logic       s0_cmd_ready, s0_data_out_ready, s0_data_in_valid, s0_data_in_last;
    logic       s1_cmd_ready, s1_data_out_ready, s1_data_in_valid, s1_data_in_last;
    logic [7:0] s0_data_in, s1_data_in;
    logic [6:0] m_cmd_address;
    logic       m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid;
    logic [7:0] m_data_out;
    logic       m_data_out_valid, m_data_out_last, m_data_in_ready;
    logic [1:0] grant;
    logic       busy, timeout_evt;

    logic       f_s0_cmd_ready, f_s0_data_out_ready, f_s0_data_in_valid, f_s0_data_in_last;
    logic       f_s1_cmd_ready, f_s1_data_out_ready, f_s1_data_in_valid, f_s1_data_in_last;
    logic [7:0] f_s0_data_in, f_s1_data_in;
    logic [6:0] f_m_cmd_address;
    logic       f_m_cmd_start, f_m_cmd_read, f_m_cmd_write, f_m_cmd_write_multiple, f_m_cmd_stop, f_m_cmd_valid;
    logic [7:0] f_m_data_out;
    logic       f_m_data_out_valid, f_m_data_out_last, f_m_data_in_ready;
    logic [1:0] f_grant;
    logic       f_busy, f_timeout_evt;

    i2c_master_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .s0_cmd_address(s0_cmd_address), .s0_cmd_start(s0_cmd_start), .s0_cmd_read(s0_cmd_read),
        .s0_cmd_write(s0_cmd_write), .s0_cmd_write_multiple(s0_cmd_write_multiple), .s0_cmd_stop(s0_cmd_stop),
        .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready),
        .s0_data_out(s0_data_out), .s0_data_out_valid(s0_data_out_valid), .s0_data_out_last(s0_data_out_last),
        .s0_data_out_ready(s0_data_out_ready), .s0_data_in(s0_data_in), .s0_data_in_valid(s0_data_in_valid),
        .s0_data_in_last(s0_data_in_last), .s0_data_in_ready(s0_data_in_ready),
        .s1_cmd_address(s1_cmd_address), .s1_cmd_start(s1_cmd_start), .s1_cmd_read(s1_cmd_read),
        .s1_cmd_write(s1_cmd_write), .s1_cmd_write_multiple(s1_cmd_write_multiple), .s1_cmd_stop(s1_cmd_stop),
        .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready),
        .s1_data_out(s1_data_out), .s1_data_out_valid(s1_data_out_valid), .s1_data_out_last(s1_data_out_last),
        .s1_data_out_ready(s1_data_out_ready), .s1_data_in(s1_data_in), .s1_data_in_valid(s1_data_in_valid),
        .s1_data_in_last(s1_data_in_last), .s1_data_in_ready(s1_data_in_ready),
        .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
        .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple), .m_cmd_stop(m_cmd_stop),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid), .m_data_out_last(m_data_out_last),
        .m_data_out_ready(m_data_out_ready), .m_data_in(m_data_in), .m_data_in_valid(m_data_in_valid),
        .m_data_in_last(m_data_in_last), .m_data_in_ready(m_data_in_ready),
        .grant(grant), .busy(busy), .timeout_evt(timeout_evt)
    );

    i2c_master_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0)) dut_fp (
        .clk(clk), .rst(rst),
        .s0_cmd_address(s0_cmd_address), .s0_cmd_start(s0_cmd_start), .s0_cmd_read(s0_cmd_read),
        .s0_cmd_write(s0_cmd_write), .s0_cmd_write_multiple(s0_cmd_write_multiple), .s0_cmd_stop(s0_cmd_stop),
        .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(f_s0_cmd_ready),
        .s0_data_out(s0_data_out), .s0_data_out_valid(s0_data_out_valid), .s0_data_out_last(s0_data_out_last),
        .s0_data_out_ready(f_s0_data_out_ready), .s0_data_in(f_s0_data_in), .s0_data_in_valid(f_s0_data_in_valid),
        .s0_data_in_last(f_s0_data_in_last), .s0_data_in_ready(s0_data_in_ready),
        .s1_cmd_address(s1_cmd_address), .s1_cmd_start(s1_cmd_start), .s1_cmd_read(s1_cmd_read),
        .s1_cmd_write(s1_cmd_write), .s1_cmd_write_multiple(s1_cmd_write_multiple), .s1_cmd_stop(s1_cmd_stop),
        .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(f_s1_cmd_ready),
        .s1_data_out(s1_data_out), .s1_data_out_valid(s1_data_out_valid), .s1_data_out_last(s1_data_out_last),
        .s1_data_out_ready(f_s1_data_out_ready), .s1_data_in(f_s1_data_in), .s1_data_in_valid(f_s1_data_in_valid),
        .s1_data_in_last(f_s1_data_in_last), .s1_data_in_ready(s1_data_in_ready),
        .m_cmd_address(f_m_cmd_address), .m_cmd_start(f_m_cmd_start), .m_cmd_read(f_m_cmd_read),
        .m_cmd_write(f_m_cmd_write), .m_cmd_write_multiple(f_m_cmd_write_multiple), .m_cmd_stop(f_m_cmd_stop),
        .m_cmd_valid(f_m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_data_out(f_m_data_out), .m_data_out_valid(f_m_data_out_valid), .m_data_out_last(f_m_data_out_last),
        .m_data_out_ready(m_data_out_ready), .m_data_in(m_data_in), .m_data_in_valid(m_data_in_valid),
        .m_data_in_last(m_data_in_last), .m_data_in_ready(f_m_data_in_ready),
        .grant(f_grant), .busy(f_busy), .timeout_evt(f_timeout_evt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        s0_cmd_address = '0; s0_cmd_start = 0; s0_cmd_read = 0; s0_cmd_write = 0;
        s0_cmd_write_multiple = 0; s0_cmd_stop = 0; s0_cmd_valid = 0;
        s1_cmd_address = '0; s1_cmd_start = 0; s1_cmd_read = 0; s1_cmd_write = 0;
        s1_cmd_write_multiple = 0; s1_cmd_stop = 0; s1_cmd_valid = 0;
        s0_data_out = '0; s0_data_out_valid = 0; s0_data_out_last = 0; s0_data_in_ready = 0;
        s1_data_out = '0; s1_data_out_valid = 0; s1_data_out_last = 0; s1_data_in_ready = 0;
        m_cmd_ready = 0; m_data_out_ready = 0;
        m_data_in = '0; m_data_in_valid = 0; m_data_in_last = 0;
    endtask

    task automatic set_cmd(input int p, input logic v, input logic [6:0] a, input logic st,
                           input logic rd, input logic wr, input logic sp);
        if (p == 0) begin
            s0_cmd_valid = v; s0_cmd_address = a; s0_cmd_start = st; s0_cmd_read = rd;
            s0_cmd_write = wr; s0_cmd_write_multiple = 0; s0_cmd_stop = sp;
        end else begin
            s1_cmd_valid = v; s1_cmd_address = a; s1_cmd_start = st; s1_cmd_read = rd;
            s1_cmd_write = wr; s1_cmd_write_multiple = 0; s1_cmd_stop = sp;
        end
    endtask

    task automatic set_dout(input int p, input logic v, input logic [7:0] d, input logic l);
        if (p == 0) begin s0_data_out_valid = v; s0_data_out = d; s0_data_out_last = l; end
        else        begin s1_data_out_valid = v; s1_data_out = d; s1_data_out_last = l; end
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    function automatic logic cmd_rdy(input int p);
        return (p == 0) ? s0_cmd_ready : s1_cmd_ready;
    endfunction

    function automatic logic dout_rdy(input int p);
        return (p == 0) ? s0_data_out_ready : s1_data_out_ready;
    endfunction

    // Arbitration rule: a lone requester wins; on a tie round-robin picks the
    // port that did not own the bus last, fixed priority picks s0.
    function automatic int winner(input bit r0, input bit r1, input bit rr, input int last);
        if (r0 && r1) return (rr && last == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    function automatic logic [1:0] onehot(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    // One write transaction from port p: start/write, one data byte, standalone stop.
    task automatic run_write(input int p, input logic [6:0] addr, input logic [7:0] data);
        int stall;
        set_cmd(p, 1, addr, 1, 0, 1, 0);
        m_cmd_ready = 1;
        settle();
        chk("idle_grant", 32'(grant), 32'(2'b00));
        chk("idle_cmd_ready", 32'(cmd_rdy(p)), 32'(1'b0));
        tick();
        chk("wr_grant", 32'(grant), 32'(onehot(p)));
        chk("wr_fp_grant", 32'(f_grant), 32'(onehot(p)));
        chk("wr_addr", 32'(m_cmd_address), 32'(addr));
        chk("wr_cmd_ready", 32'(cmd_rdy(p)), 32'(1'b1));
        chk("wr_other_ready", 32'(cmd_rdy(1 - p)), 32'(1'b0));
        tick();
        set_cmd(p, 0, 7'h00, 0, 0, 0, 0);
        set_dout(p, 1, data, 1);
        m_data_out_ready = 0;
        stall = $urandom_range(0, 3);
        repeat (stall) begin
            settle();
            chk("wr_stall_ready", 32'(dout_rdy(p)), 32'(1'b0));
            tick();
        end
        m_data_out_ready = 1;
        settle();
        chk("wr_data", 32'(m_data_out), 32'(data));
        chk("wr_data_last", 32'(m_data_out_last), 32'(1'b1));
        chk("wr_data_ready", 32'(dout_rdy(p)), 32'(1'b1));
        tick();
        set_dout(p, 0, 8'h00, 0);
        set_cmd(p, 1, 7'h00, 0, 0, 0, 1);
        settle();
        chk("wr_stop", 32'(m_cmd_stop), 32'(1'b1));
        tick();
        set_cmd(p, 0, 7'h00, 0, 0, 0, 0);
        settle();
        chk("wr_release_grant", 32'(grant), 32'(2'b00));
        chk("wr_release_busy", 32'(busy), 32'(1'b0));
    endtask

    // ---------------- directed/randomized sequence ----------------
    initial begin
        int last_rr, last_fp, w_rr, w_fp, gap;
        bit r0, r1;
        logic [7:0] b;
        logic [6:0] a;

        // Reset state, with master-side readies and read-valid held high.
        do_reset();
        m_cmd_ready = 1; m_data_out_ready = 1; m_data_in_valid = 1;
        s0_data_in_ready = 1; s1_data_in_ready = 1;
        settle();
        chk("rst_grant", 32'(grant), 32'(2'b00));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_evt", 32'(timeout_evt), 32'(1'b0));
        chk("rst_m_cmd_valid", 32'(m_cmd_valid), 32'(1'b0));
        chk("rst_m_dout_valid", 32'(m_data_out_valid), 32'(1'b0));
        chk("rst_s0_cmd_ready", 32'(s0_cmd_ready), 32'(1'b0));
        chk("rst_s1_dout_ready", 32'(s1_data_out_ready), 32'(1'b0));
        chk("rst_s0_din_valid", 32'(s0_data_in_valid), 32'(1'b0));
        chk("rst_s1_din_valid", 32'(s1_data_in_valid), 32'(1'b0));
        chk("rst_m_din_ready", 32'(m_data_in_ready), 32'(1'b1));
        clear_inputs();
        tick();

        // Single-requester writes: the fixed case, then random ports and data.
        run_write(0, 7'h1A, 8'h55);
        for (int i = 0; i < 6; i++) begin
            a = 7'($urandom_range(0, 127));
            b = 8'($urandom_range(0, 255));
            run_write(int'($urandom_range(0, 1)), a, b);
        end

        // Contention: stop-only commands, three ties then random request patterns.
        do_reset();
        last_rr = 1;
        last_fp = 1;
        m_cmd_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (i < 3) begin r0 = 1; r1 = 1; end
            else begin
                r0 = 1'($urandom_range(0, 1));
                r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            set_cmd(0, r0, 7'h00, 0, 0, 0, 1);
            set_cmd(1, r1, 7'h00, 0, 0, 0, 1);
            settle();
            chk("arb_idle_grant", 32'(grant), 32'(2'b00));
            chk("arb_gap_valid", 32'(m_cmd_valid), 32'(1'b0));
            w_rr = winner(r0, r1, 1'b1, last_rr);
            w_fp = winner(r0, r1, 1'b0, last_fp);
            tick();
            chk("arb_rr_grant", 32'(grant), 32'(onehot(w_rr)));
            chk("arb_fp_grant", 32'(f_grant), 32'(onehot(w_fp)));
            chk("arb_win_ready", 32'(cmd_rdy(w_rr)), 32'(1'b1));
            chk("arb_lose_ready", 32'(cmd_rdy(1 - w_rr)), 32'(1'b0));
            tick();
            last_rr = w_rr;
            last_fp = w_fp;
        end
        clear_inputs();
        tick();

        // s1 requests during an s0 transaction: blocked until the stop, granted two cycles later.
        m_cmd_ready = 1;
        m_data_out_ready = 1;
        set_cmd(0, 1, 7'($urandom_range(0, 127)), 1, 0, 1, 0);
        tick();
        chk("blk_s0_grant", 32'(grant), 32'(2'b01));
        tick();
        set_cmd(0, 0, 7'h00, 0, 0, 0, 0);
        set_cmd(1, 1, 7'h00, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            set_dout(0, 1, b, 1'(i == 2));
            settle();
            chk("blk_s1_ready", 32'(s1_cmd_ready), 32'(1'b0));
            chk("blk_data", 32'(m_data_out), 32'(b));
            tick();
        end
        set_dout(0, 0, 8'h00, 0);
        set_cmd(0, 1, 7'h00, 0, 0, 0, 1);
        settle();
        chk("blk_s1_ready_stop", 32'(s1_cmd_ready), 32'(1'b0));
        tick();
        set_cmd(0, 0, 7'h00, 0, 0, 0, 0);
        settle();
        chk("blk_gap_grant", 32'(grant), 32'(2'b00));
        chk("blk_gap_valid", 32'(m_cmd_valid), 32'(1'b0));
        chk("blk_gap_s1_ready", 32'(s1_cmd_ready), 32'(1'b0));
        tick();
        chk("blk_s1_grant", 32'(grant), 32'(2'b10));
        chk("blk_s1_fp_grant", 32'(f_grant), 32'(2'b10));
        chk("blk_s1_ready_own", 32'(s1_cmd_ready), 32'(1'b1));
        tick();
        set_cmd(1, 0, 7'h00, 0, 0, 0, 0);
        settle();
        chk("blk_end_grant", 32'(grant), 32'(2'b00));

        // s1 read: read bytes reach s1 only; ready flows back from s1.
        set_cmd(1, 1, 7'($urandom_range(0, 127)), 1, 1, 0, 0);
        tick();
        chk("rd_grant", 32'(grant), 32'(2'b10));
        chk("rd_cmd_read", 32'(m_cmd_read), 32'(1'b1));
        tick();
        set_cmd(1, 0, 7'h00, 0, 0, 0, 0);
        s0_data_in_ready = 1;
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'hA3 : 8'($urandom_range(0, 255));
            m_data_in = b; m_data_in_valid = 1; m_data_in_last = 1'(i == 2);
            s1_data_in_ready = 1;
            settle();
            chk("rd_data", 32'(s1_data_in), 32'(b));
            chk("rd_valid", 32'(s1_data_in_valid), 32'(1'b1));
            chk("rd_last", 32'(s1_data_in_last), 32'(i == 2));
            chk("rd_s0_valid", 32'(s0_data_in_valid), 32'(1'b0));
            chk("rd_m_ready", 32'(m_data_in_ready), 32'(1'b1));
            tick();
        end
        s1_data_in_ready = 0;
        settle();
        chk("rd_backpressure", 32'(m_data_in_ready), 32'(1'b0));
        tick();
        m_data_in_valid = 0;
        set_cmd(1, 1, 7'h00, 0, 0, 0, 1);
        tick();
        set_cmd(1, 0, 7'h00, 0, 0, 0, 0);
        m_data_in_valid = 1;
        settle();
        chk("rd_idle_grant", 32'(grant), 32'(2'b00));
        chk("rd_idle_m_ready", 32'(m_data_in_ready), 32'(1'b1));
        chk("rd_idle_s1_valid", 32'(s1_data_in_valid), 32'(1'b0));
        clear_inputs();
        tick();

        // Timeout: short quiet gaps are forgiven, 8 consecutive quiet cycles evict s0.
        do_reset();
        m_cmd_ready = 1;
        set_cmd(0, 1, 7'($urandom_range(1, 127)), 1, 0, 1, 0);
        tick();
        chk("to_grant", 32'(grant), 32'(2'b01));
        tick();
        set_cmd(0, 0, 7'h00, 0, 0, 0, 0);
        m_cmd_ready = 0;
        m_data_out_ready = 1;
        for (int g = 0; g < 2; g++) begin
            gap = $urandom_range(1, 7);
            repeat (gap) begin
                settle();
                chk("to_gap_grant", 32'(grant), 32'(2'b01));
                tick();
            end
            set_dout(0, 1, 8'($urandom_range(0, 255)), 0);
            settle();
            chk("to_gap_evt", 32'(timeout_evt), 32'(1'b0));
            tick();
            set_dout(0, 0, 8'h00, 0);
        end
        repeat (8) begin
            settle();
            chk("to_quiet_grant", 32'(grant), 32'(2'b01));
            chk("to_quiet_evt", 32'(timeout_evt), 32'(1'b0));
            tick();
        end
        chk("to_fstop_grant", 32'(grant), 32'(2'b00));
        chk("to_fstop_busy", 32'(busy), 32'(1'b1));
        chk("to_evt", 32'(timeout_evt), 32'(1'b1));
        chk("to_stop_valid", 32'(m_cmd_valid), 32'(1'b1));
        chk("to_stop_flag", 32'(m_cmd_stop), 32'(1'b1));
        chk("to_stop_addr", 32'(m_cmd_address), 32'(7'h00));
        chk("to_stop_start", 32'(m_cmd_start), 32'(1'b0));
        chk("to_stop_write", 32'(m_cmd_write), 32'(1'b0));
        chk("to_stop_dout", 32'(m_data_out_valid), 32'(1'b0));
        chk("to_fp_still_own", 32'(f_grant), 32'(2'b01));
        tick();
        chk("to_evt_pulse", 32'(timeout_evt), 32'(1'b0));
        chk("to_fstop_hold", 32'(busy), 32'(1'b1));
        m_cmd_ready = 1;
        settle();
        chk("to_s0_blocked", 32'(s0_cmd_ready), 32'(1'b0));
        chk("to_s1_blocked", 32'(s1_cmd_ready), 32'(1'b0));
        tick();
        chk("to_idle_busy", 32'(busy), 32'(1'b0));
        set_cmd(0, 1, 7'h00, 0, 0, 0, 1);
        set_cmd(1, 1, 7'h00, 0, 0, 0, 1);
        tick();
        chk("to_next_winner", 32'(grant), 32'(onehot(winner(1, 1, 1'b1, 0))));
        tick();

        // Reset while s1 is mid-write; data_out_valid alone must not re-request.
        do_reset();
        m_cmd_ready = 1;
        set_cmd(1, 1, 7'($urandom_range(0, 127)), 1, 0, 1, 0);
        tick();
        chk("mr_grant", 32'(grant), 32'(2'b10));
        tick();
        set_cmd(1, 0, 7'h00, 0, 0, 0, 0);
        set_dout(1, 1, 8'($urandom_range(0, 255)), 0);
        m_data_out_ready = 0;
        settle();
        chk("mr_dout_valid", 32'(m_data_out_valid), 32'(1'b1));
        rst = 1;
        tick();
        rst = 0;
        m_data_out_ready = 1;
        settle();
        chk("mr_grant_after", 32'(grant), 32'(2'b00));
        chk("mr_cmd_valid", 32'(m_cmd_valid), 32'(1'b0));
        chk("mr_dout_valid_after", 32'(m_data_out_valid), 32'(1'b0));
        chk("mr_busy", 32'(busy), 32'(1'b0));
        chk("mr_s1_dout_ready", 32'(s1_data_out_ready), 32'(1'b0));
        tick();
        chk("mr_no_request", 32'(grant), 32'(2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
